addsubcmp_arbiter: RTL and testbench
====================================

Name: addsubcmp_arbiter

Overview:
- Shares one combinational AddSubCmp datapath (16-bit add/sub/compare with Carry/Zero/Sign/Overflow flags) between NumReq requesters in the WSN SoC.
- Round-robin arbitration with a req/ack handshake.
- Sequences the operation as grant, then operand drive, then result capture.
- Returns a registered result and flags to the granted requester.
- Sits between the reconfigurable-logic requesters and the single AddSubCmp cell instance, which is external to this block.

Parameters:
- NumReq, 4, number of requesters (2..8).
- Width, 16, operand/result width; must match the AddSubCmp cell.

Ports:
- Clk_i  in  1  clock; all state changes on the rising edge.
- Reset_i  in  1  asynchronous, active-high reset.
- Req_i  in  NumReq  per-requester request, level, held until Ack.
- Op_i  in  2*NumReq  per-requester opcode; requester k uses bits [2k+1:2k]. 00=add, 01=sub, 10=greater (unsigned A>B), 11=equal.
- A_i  in  Width*NumReq  per-requester operand A, slice k.
- B_i  in  Width*NumReq  per-requester operand B, slice k.
- Ack_o  out  NumReq  one-cycle completion pulse, one-hot.
- Result_o  out  Width  registered D for add/sub; zero-extended compare bit for greater/equal.
- Carry_o  out  1  registered carry flag.
- Zero_o  out  1  registered zero flag.
- Sign_o  out  1  registered sign flag.
- Overflow_o  out  1  registered overflow flag.
- Busy_o  out  1  high in EXEC and DONE.
- CmpAddOrSub_o  out  1  to cell AddOrSub_i: 0 for add, 1 otherwise.
- CmpA_o  out  Width  to cell A_i, registered.
- CmpB_o  out  Width  to cell B_i, registered.
- CmpCarry_o  out  1  to cell Carry_i; always 0.
- CmpD_i  in  Width  from cell D_o.
- CmpCarry_i  in  1  from cell Carry_o.
- CmpZero_i  in  1  from cell Zero_o.
- CmpSign_i  in  1  from cell Sign_o.
- CmpOverflow_i  in  1  from cell Overflow_o.

Behaviour:
- Reset (async, any state):
  - State=IDLE, round-robin pointer=0.
  - Ack_o=0, Result_o=0, all flags=0, Busy_o=0.
  - CmpA_o=0, CmpB_o=0, CmpAddOrSub_o=0.
  - Reset mid-EXEC aborts the operation; no Ack is issued.
- IDLE:
  - If any Req_i bit is set, choose the winner by round-robin: the first set bit searching upward from the pointer and wrapping past NumReq-1 to 0.
  - On the edge, latch the winner index and drive CmpA_o, CmpB_o and CmpAddOrSub_o from the winner's slices and opcode.
  - Go to EXEC.
- EXEC (1 cycle): the cell evaluates combinationally. On the edge, capture into the output registers:
  - Add/sub: Result_o=CmpD_i.
  - Greater: Result_o={0..,CmpCarry_i & ~CmpZero_i}.
  - Equal: Result_o={0..,CmpZero_i}.
  - All opcodes: flags = cell flags.
  - Ack_o[winner]=1.
  - Go to DONE.
- DONE (1 cycle):
  - Ack_o is high only in this cycle; Ack_o is cleared on the next edge.
  - Pointer = winner+1, wrapping to 0 after NumReq-1.
  - Go to IDLE.
- Hold rules:
  - Result_o and the flags hold their value until the next capture.
  - Operands are sampled only in IDLE; changes to Req/Op/A/B during EXEC or DONE are ignored.
- Latency: Req seen in IDLE at edge n leads to Ack high during cycle n+2. Throughput is one operation per 3 cycles.
- Requester drop rules:
  - A requester must drop Req_i in the cycle after Ack. If Req_i is still high in IDLE, it counts as a new request and is arbitrated normally, behind the others because of the pointer.
  - A requester that drops Req before it is granted is simply not served; there is no error.
- Fairness: with all requesters asserting, each is granted once per NumReq operations.
- Arithmetic: modulo 2^Width. Flag semantics are exactly those of the cell; CmpCarry_o is tied to 0.

Test Plan:
- Single add: Req0, Op=00, A=0x7FFF, B=0x0001 -> Ack_o=0001 two cycles after the request edge; Result=0x8000, Overflow=1, Sign=1, Zero=0.
- Greater and equal on req2: A=0x1234, B=0x1233 with Op=10 -> Result=1. Same A/B with Op=11 -> Result=0. A=B=0xFFFF with Op=10 -> Result=0; with Op=11 -> Result=1 and Zero=1.
- Round-robin: all four Req held high continuously -> Ack order 0,1,2,3,0 with Ack pulses 3 cycles apart. Then pointer=1 and only Req0|Req3 set -> Ack3 first, then Ack0.
- Sub wrap: A=0x0000, B=0x0001, Op=01 -> Result=0xFFFF, Carry=0, Sign=1.
- Operand change during EXEC: change A_i in EXEC -> Result reflects the operands latched in IDLE.
- Reset asserted asynchronously mid-EXEC -> all outputs 0 immediately, no Ack. A request after release is served with pointer=0.

Source files
------------

// File: rtl/addsubcmp_arbiter.sv
// addsubcmp_arbiter
//   Shares one external combinational AddSubCmp cell between NumReq requesters.
//   A round-robin arbiter picks a requester in IDLE and latches its operands
//   into the cell-facing registers. The cell evaluates during EXEC. Its result
//   and flags are captured at the end of EXEC. A one-cycle Ack pulse is shown
//   to the winner during DONE.
//
// Ports
//   Clk_i, Reset_i         clock, asynchronous active-high reset
//   Req_i[NumReq]          level requests, held until Ack
//   Op_i[2*NumReq]         per-requester opcode: 00 add, 01 sub, 10 A>B (unsigned), 11 A==B
//   A_i, B_i               per-requester operands, Width bits per slice
//   Ack_o[NumReq]          one-hot completion pulse
//   Result_o, flags        registered result / Carry / Zero / Sign / Overflow
//   Busy_o                 high while an operation is in flight (EXEC, DONE)
//   CmpAddOrSub_o, CmpA_o, CmpB_o, CmpCarry_o   drive the cell inputs
//   CmpD_i, Cmp*_i         cell outputs
module addsubcmp_arbiter #(
  parameter int NumReq = 4,
  parameter int Width  = 16
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic [NumReq-1:0]       Req_i,
  input  logic [2*NumReq-1:0]     Op_i,
  input  logic [Width*NumReq-1:0] A_i,
  input  logic [Width*NumReq-1:0] B_i,
  output logic [NumReq-1:0]       Ack_o,
  output logic [Width-1:0]        Result_o,
  output logic                    Carry_o,
  output logic                    Zero_o,
  output logic                    Sign_o,
  output logic                    Overflow_o,
  output logic                    Busy_o,
  output logic                    CmpAddOrSub_o,
  output logic [Width-1:0]        CmpA_o,
  output logic [Width-1:0]        CmpB_o,
  output logic                    CmpCarry_o,
  input  logic [Width-1:0]        CmpD_i,
  input  logic                    CmpCarry_i,
  input  logic                    CmpZero_i,
  input  logic                    CmpSign_i,
  input  logic                    CmpOverflow_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_reg;
  logic [IdxW-1:0] ptr_reg;
  logic [IdxW-1:0] winner_reg;
  logic [1:0]      op_reg;

  logic [IdxW-1:0] grant_idx_next;
  logic            grant_valid_next;

  logic [1:0]       op_slice [NumReq];
  logic [Width-1:0] a_slice  [NumReq];
  logic [Width-1:0] b_slice  [NumReq];

  // Split the flat per-requester buses into indexable slices.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
      assign op_slice[gi] = Op_i[2*gi +: 2];
      assign a_slice[gi]  = A_i[Width*gi +: Width];
      assign b_slice[gi]  = B_i[Width*gi +: Width];
    end
  endgenerate

  // (base + off) modulo NumReq, for off < NumReq.
  function automatic logic [IdxW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NumReq) s = s - NumReq;
    return s[IdxW-1:0];
  endfunction

  // Round-robin search: scan offsets from the highest down to zero, so the
  // set request nearest to the pointer (offset 0 first) is the last to be
  // written and therefore wins.
  always_comb begin
    grant_valid_next = 1'b0;
    grant_idx_next   = '0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      if (Req_i[wrap_idx(int'(ptr_reg), off)]) begin
        grant_valid_next = 1'b1;
        grant_idx_next   = wrap_idx(int'(ptr_reg), off);
      end
    end
  end

  // The cell carry-in is never used. Subtraction gets its +1 inside the cell.
  assign CmpCarry_o = 1'b0;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      winner_reg    <= '0;
      op_reg        <= 2'b00;
      Ack_o         <= '0;
      Result_o      <= '0;
      Carry_o       <= 1'b0;
      Zero_o        <= 1'b0;
      Sign_o        <= 1'b0;
      Overflow_o    <= 1'b0;
      Busy_o        <= 1'b0;
      CmpAddOrSub_o <= 1'b0;
      CmpA_o        <= '0;
      CmpB_o        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid_next) begin
            winner_reg    <= grant_idx_next;
            op_reg        <= op_slice[grant_idx_next];
            CmpA_o        <= a_slice[grant_idx_next];
            CmpB_o        <= b_slice[grant_idx_next];
            // Compares are subtractions. Only opcode 00 adds.
            CmpAddOrSub_o <= (op_slice[grant_idx_next] != 2'b00);
            Busy_o        <= 1'b1;
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          case (op_reg)
            2'b10:   Result_o <= {{(Width-1){1'b0}}, CmpCarry_i & ~CmpZero_i};
            2'b11:   Result_o <= {{(Width-1){1'b0}}, CmpZero_i};
            default: Result_o <= CmpD_i;
          endcase
          Carry_o    <= CmpCarry_i;
          Zero_o     <= CmpZero_i;
          Sign_o     <= CmpSign_i;
          Overflow_o <= CmpOverflow_i;
          Ack_o      <= {{(NumReq-1){1'b0}}, 1'b1} << winner_reg;
          state_reg  <= DONE;
        end
        DONE: begin
          Ack_o     <= '0;
          ptr_reg   <= wrap_idx(int'(winner_reg), 1);
          Busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsubcmp_arbiter.sv
// Scoreboard bench for addsubcmp_arbiter. The stimulus pushes hand-computed
// expected responses. A negedge monitor pops one entry per Ack and compares it.
// The external AddSubCmp cell is modelled combinationally in this bench.
module tb_addsubcmp_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_v = '0;
  logic [2*N-1:0] op_v  = '0;
  logic [W*N-1:0] a_v   = '0;
  logic [W*N-1:0] b_v   = '0;

  logic [N-1:0] ack;
  logic [W-1:0] result;
  logic         carry, zero, sign, ovf, busy;
  logic         cmp_addsub, cmp_cin;
  logic [W-1:0] cmp_a, cmp_b;
  logic [W-1:0] cell_d;
  logic         cell_c, cell_z, cell_s, cell_v;

  always #5 clk = ~clk;

  addsubcmp_arbiter #(.NumReq(N), .Width(W)) dut (
    .Clk_i(clk), .Reset_i(rst), .Req_i(req_v), .Op_i(op_v), .A_i(a_v), .B_i(b_v),
    .Ack_o(ack), .Result_o(result), .Carry_o(carry), .Zero_o(zero), .Sign_o(sign),
    .Overflow_o(ovf), .Busy_o(busy), .CmpAddOrSub_o(cmp_addsub), .CmpA_o(cmp_a),
    .CmpB_o(cmp_b), .CmpCarry_o(cmp_cin), .CmpD_i(cell_d), .CmpCarry_i(cell_c),
    .CmpZero_i(cell_z), .CmpSign_i(cell_s), .CmpOverflow_i(cell_v)
  );

  // Stand-in for the AddSubCmp cell: add = A+B+Cin, sub = A+~B+1.
  // Carry = carry out. For sub, carry out means no borrow.
  logic [W:0] cell_sum;
  always_comb begin
    if (cmp_addsub) cell_sum = {1'b0, cmp_a} + {1'b0, ~cmp_b} + 17'd1;
    else            cell_sum = {1'b0, cmp_a} + {1'b0, cmp_b} + {16'd0, cmp_cin};
    cell_d = cell_sum[W-1:0];
    cell_c = cell_sum[W];
    cell_z = (cell_d == '0);
    cell_s = cell_d[W-1];
    if (cmp_addsub) cell_v = (cmp_a[W-1] != cmp_b[W-1]) && (cell_d[W-1] != cmp_a[W-1]);
    else            cell_v = (cmp_a[W-1] == cmp_b[W-1]) && (cell_d[W-1] != cmp_a[W-1]);
  end

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic [3:0]  fl;   // {carry, zero, sign, overflow}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Ack must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      exp_t e;
      check("ack_onehot", {31'd0, $onehot(ack)}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack=%b, expected no ack (t=%0t)", ack, $time);
      end else begin
        e = exp_q.pop_front();
        check("ack_idx", {28'd0, ack}, 32'd1 << e.idx);
        check("result", {16'd0, result}, {16'd0, e.res});
        check("flags_czsv", {28'd0, carry, zero, sign, ovf}, {28'd0, e.fl});
        $display("ack req%0d result=%h flags=%b", e.idx, result, {carry, zero, sign, ovf});
      end
    end
  end

  task automatic set_slice(input int k, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    op_v[2*k +: 2] = op;
    a_v[W*k +: W]  = a;
    b_v[W*k +: W]  = b;
  endtask

  // One request on requester k. The call starts and ends on a negedge.
  task automatic do_op(input int k, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] res, input logic [3:0] fl,
                       input bit chk_lat, input bit poke_a);
    int lat;
    bit got;
    exp_q.push_back('{k, res, fl});
    set_slice(k, op, a, b);
    req_v[k] = 1'b1;
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && poke_a) a_v[W*k +: W] = 16'h5000;  // DUT is in EXEC now
      if (ack[k]) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack on req%0d, expected one within 20 cycles", k);
    end else if (chk_lat) begin
      check("ack_latency", lat, 2);
      check("busy_in_done", {31'd0, busy}, 32'd1);
    end
    req_v[k] = 1'b0;
    repeat (3) @(negedge clk);
    check("result_hold", {16'd0, result}, {16'd0, res});
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Two requests raised together. Each requester drops as soon as it is acked.
  task automatic pair_serve(input int first, input int second);
    int served;
    served = 0;
    req_v[first]  = 1'b1;
    req_v[second] = 1'b1;
    for (int i = 0; i < 20 && served < 2; i++) begin
      @(negedge clk);
      if (ack[first])  begin req_v[first]  = 1'b0; served++; end
      if (ack[second]) begin req_v[second] = 1'b0; served++; end
    end
    check("pair_served", served, 2);
    req_v = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t_ack[5];
    int n_ack;
    int cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {28'd0, carry, zero, sign, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmp", {cmp_a, cmp_b}, 32'd0);
    check("rst_addsub", {31'd0, cmp_addsub}, 32'd0);
    check("cmp_carry_tied", {31'd0, cmp_cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single add with signed overflow
    do_op(0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1, 0);
    // Greater / equal on requester 2
    do_op(2, 2'b10, 16'h1234, 16'h1233, 16'h0001, 4'b1000, 1, 0);
    do_op(2, 2'b11, 16'h1234, 16'h1233, 16'h0000, 4'b1000, 0, 0);
    do_op(2, 2'b10, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1100, 0, 0);
    do_op(2, 2'b11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1100, 0, 0);
    // Sub wrap on requester 3; pointer becomes 0 afterwards
    do_op(3, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 1, 0);

    // Round robin: all four requests held high
    set_slice(0, 2'b00, 16'h0001, 16'h0002);
    set_slice(1, 2'b00, 16'hFFFF, 16'h0001);
    set_slice(2, 2'b00, 16'h8000, 16'h8000);
    set_slice(3, 2'b00, 16'h0010, 16'h0020);
    exp_q.push_back('{0, 16'h0003, 4'b0000});
    exp_q.push_back('{1, 16'h0000, 4'b1100});
    exp_q.push_back('{2, 16'h0000, 4'b1101});
    exp_q.push_back('{3, 16'h0030, 4'b0000});
    exp_q.push_back('{0, 16'h0003, 4'b0000});
    req_v = 4'hF;
    n_ack = 0;
    cyc = 0;
    for (int i = 0; i < 40 && n_ack < 5; i++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        t_ack[n_ack] = cyc;
        n_ack++;
        if (n_ack == 5) req_v = '0;
      end
    end
    req_v = '0;
    check("rr_ack_count", n_ack, 5);
    if (n_ack == 5)
      for (int i = 1; i < 5; i++) check("rr_ack_spacing", t_ack[i] - t_ack[i-1], 3);
    repeat (3) @(negedge clk);

    // Pointer is now 1: with req0 and req3, req3 must win first
    exp_q.push_back('{3, 16'h0030, 4'b0000});
    exp_q.push_back('{0, 16'h0003, 4'b0000});
    pair_serve(0, 3);

    // Operand change during EXEC is ignored; pointer becomes 2
    do_op(1, 2'b00, 16'h0100, 16'h0001, 16'h0101, 4'b0000, 1, 1);

    // Asynchronous reset in the middle of EXEC
    set_slice(0, 2'b00, 16'h0005, 16'h0006);
    req_v[0] = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", {28'd0, ack}, 32'd0);
    check("arst_result", {16'd0, result}, 32'd0);
    check("arst_flags", {28'd0, carry, zero, sign, ovf}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cmp", {cmp_a, cmp_b}, 32'd0);
    check("arst_addsub", {31'd0, cmp_addsub}, 32'd0);
    req_v = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Pointer was reset to 0: req1 must beat req3
    set_slice(1, 2'b00, 16'h0002, 16'h0003);
    set_slice(3, 2'b01, 16'h0005, 16'h0005);
    exp_q.push_back('{1, 16'h0005, 4'b0000});
    exp_q.push_back('{3, 16'h0000, 4'b1100});
    pair_serve(1, 3);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
